phasemean_ctrl: RTL and testbench

Sequencer for the six-channel `phasemean` accumulator.
- Collects one phase sample per hydrophone channel from independently timed upstream phase detectors, then issues each complete six-channel set to `phasemean` as a single-cycle `enable` pulse with stable sample buses.
- Counts issued sets against N = 2^K and flags when the mean is ready.
- Sits between the per-channel phase estimators and `phasemean` in the USBL receive chain.

---
 rtl/phasemean_pkg.sv | 28 ++
 rtl/phase_capture.sv | 42 ++++
 rtl/phasemean_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_phasemean_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phasemean_pkg.sv
// Shared constants, state encoding and K clamp for the phasemean sequencer.
package phasemean_pkg;

    localparam int unsigned PM_WIDTH = 16;
    localparam int unsigned PM_KMAX  = 10;
    localparam int unsigned PM_NCH   = 6;
    localparam int unsigned PM_KW    = 10;
    localparam int unsigned PM_CNTW  = 11;
    localparam int unsigned PM_DROPW = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_DONE    = 3'd4
    } pm_state_e;

    // Limit the requested log2 set count to what the accumulator supports.
    function automatic logic [PM_KW-1:0] clamp_k(input logic [PM_KW-1:0] k,
                                                 input int unsigned     kmax);
        if (32'(k) > kmax) begin
            return PM_KW'(kmax);
        end
        return k;
    endfunction

endpackage

// File: rtl/phase_capture.sv
// One channel's holding register and captured flag; a strobe in the same
// cycle as clear starts the next set.
module phase_capture
    import phasemean_pkg::*;
#(
    parameter int unsigned WIDTH = PM_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    strobe,
    input  logic signed [WIDTH-1:0] data,
    input  logic                    clear,
    output logic signed [WIDTH-1:0] hold,
    output logic                    got
);

    logic signed [WIDTH-1:0] hold_q, hold_d;
    logic                    got_q, got_d;

    always_comb begin
        hold_d = hold_q;
        got_d  = got_q & ~clear;
        if (strobe) begin
            hold_d = data;
            got_d  = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
            got_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            got_q  <= got_d;
        end
    end

    assign hold = hold_q;
    assign got  = got_q;

endmodule

// File: rtl/phasemean_ctrl.sv
// Collects one sample per channel, issues complete sets to phasemean and
// flags the mean after 2^K sets. PHASEMEAN_CTRL_TIMEOUT_EN adds set timeout.
module phasemean_ctrl
    import phasemean_pkg::*;
#(
    parameter int unsigned WIDTH   = PM_WIDTH,
    parameter int unsigned KMAX    = PM_KMAX,
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [PM_KW-1:0]        K,
    input  logic [PM_NCH-1:0]       phase_valid,
    input  logic signed [WIDTH-1:0] in_phase_1,
    input  logic signed [WIDTH-1:0] in_phase_2,
    input  logic signed [WIDTH-1:0] in_phase_3,
    input  logic signed [WIDTH-1:0] in_phase_4,
    input  logic signed [WIDTH-1:0] in_phase_5,
    input  logic signed [WIDTH-1:0] in_phase_6,
    output logic                    pm_enable,
    output logic signed [WIDTH-1:0] pm_sampl_1,
    output logic signed [WIDTH-1:0] pm_sampl_2,
    output logic signed [WIDTH-1:0] pm_sampl_3,
    output logic signed [WIDTH-1:0] pm_sampl_4,
    output logic signed [WIDTH-1:0] pm_sampl_5,
    output logic signed [WIDTH-1:0] pm_sampl_6,
    output logic [PM_KW-1:0]        pm_K,
    output logic                    busy,
    output logic                    mean_valid,
    output logic [PM_CNTW-1:0]      set_count,
    output logic [PM_DROPW-1:0]     drop_count
);

    localparam int unsigned       SET_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [PM_NCH-1:0] ALL_GOT = '1;

    pm_state_e               state_q, state_d;
    logic                    pm_enable_q, pm_enable_d;
    logic                    mean_valid_q, mean_valid_d;
    logic                    busy_q, busy_d;
    logic [PM_KW-1:0]        pm_k_q, pm_k_d;
    logic [PM_CNTW-1:0]      set_count_q, set_count_d;
    logic [PM_DROPW-1:0]     drop_count_q, drop_count_d;
    logic [SET_W-1:0]        settle_q, settle_d;
    logic signed [WIDTH-1:0] sampl_q [PM_NCH];
    logic signed [WIDTH-1:0] sampl_d [PM_NCH];

    logic signed [WIDTH-1:0] in_phase_c [PM_NCH];
    logic signed [WIDTH-1:0] hold_c     [PM_NCH];
    logic [PM_NCH-1:0]       got_c;
    logic [PM_NCH-1:0]       strobe_c;
    logic                    capture_c;
    logic                    clear_c;
    logic                    set_full_c;
    logic                    drop_c;

    assign in_phase_c[0] = in_phase_1;
    assign in_phase_c[1] = in_phase_2;
    assign in_phase_c[2] = in_phase_3;
    assign in_phase_c[3] = in_phase_4;
    assign in_phase_c[4] = in_phase_5;
    assign in_phase_c[5] = in_phase_6;

    // Strobes count only while a set is being gathered, including the issue
    // cycle, where they seed the next set after the clear.
    assign capture_c  = (state_q == ST_COLLECT) || (state_q == ST_ISSUE);
    assign strobe_c   = phase_valid & {PM_NCH{capture_c}};
    assign clear_c    = (state_q != ST_COLLECT) || drop_c;
    assign set_full_c = ((got_c | strobe_c) == ALL_GOT);

    for (genvar i = 0; i < PM_NCH; i++) begin : g_ch
        phase_capture #(
            .WIDTH (WIDTH)
        ) u_capture (
            .clock  (clock),
            .reset  (reset),
            .strobe (strobe_c[i]),
            .data   (in_phase_c[i]),
            .clear  (clear_c),
            .hold   (hold_c[i]),
            .got    (got_c[i])
        );
    end

`ifdef PHASEMEAN_CTRL_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Timer runs from the first capture of a set; an incomplete set at expiry is dropped.
    assign drop_c = (state_q == ST_COLLECT) && (got_c != '0) &&
                    (tmo_q == TMO_W'(TIMEOUT - 1)) && !set_full_c;

    always_comb begin
        tmo_d = tmo_q + TMO_W'(1);
        if ((state_q != ST_COLLECT) || (got_c == '0) || drop_c) begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_timeout_c;

    // Without the timeout build the set waits indefinitely.
    assign drop_c           = 1'b0;
    assign unused_timeout_c = (TIMEOUT != 0);
`endif

    always_comb begin
        state_d      = state_q;
        pm_enable_d  = 1'b0;
        mean_valid_d = 1'b0;
        busy_d       = busy_q;
        pm_k_d       = pm_k_q;
        set_count_d  = set_count_q;
        drop_count_d = drop_count_q;
        settle_d     = settle_q;
        sampl_d      = sampl_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pm_k_d      = clamp_k(K, KMAX);
                    set_count_d = '0;
                    busy_d      = 1'b1;
                    state_d     = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (set_full_c) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                pm_enable_d = 1'b1;
                sampl_d     = hold_c;
                set_count_d = set_count_q + PM_CNTW'(1);
                if (set_count_d == (PM_CNTW'(1) << pm_k_q)) begin
                    settle_d = '0;
                    state_d  = ST_SETTLE;
                end else begin
                    state_d  = ST_COLLECT;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SET_W'(SETTLE - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            ST_DONE: begin
                mean_valid_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (drop_c && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + PM_DROPW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            pm_enable_q  <= 1'b0;
            mean_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            pm_k_q       <= '0;
            set_count_q  <= '0;
            drop_count_q <= '0;
            settle_q     <= '0;
            sampl_q      <= '{default: '0};
        end else begin
            state_q      <= state_d;
            pm_enable_q  <= pm_enable_d;
            mean_valid_q <= mean_valid_d;
            busy_q       <= busy_d;
            pm_k_q       <= pm_k_d;
            set_count_q  <= set_count_d;
            drop_count_q <= drop_count_d;
            settle_q     <= settle_d;
            sampl_q      <= sampl_d;
        end
    end

    assign pm_enable  = pm_enable_q;
    assign mean_valid = mean_valid_q;
    assign busy       = busy_q;
    assign pm_K       = pm_k_q;
    assign set_count  = set_count_q;
    assign drop_count = drop_count_q;
    assign pm_sampl_1 = sampl_q[0];
    assign pm_sampl_2 = sampl_q[1];
    assign pm_sampl_3 = sampl_q[2];
    assign pm_sampl_4 = sampl_q[3];
    assign pm_sampl_5 = sampl_q[4];
    assign pm_sampl_6 = sampl_q[5];

endmodule

// File: tb/tb_phasemean_ctrl.sv
// Randomized bench for phasemean_ctrl against a set-level reference model.
module tb_phasemean_ctrl;

    localparam int unsigned SETTLE_C = 4;

    typedef logic [5:0][15:0] set_t;

    logic               clock;
    logic               reset;
    logic               start;
    logic [9:0]         k_in;
    logic [5:0]         phase_valid;
    logic signed [15:0] ph  [6];
    logic signed [15:0] smp [6];
    logic               pm_enable;
    logic [9:0]         pm_K;
    logic               busy;
    logic               mean_valid;
    logic [10:0]        set_count;
    logic [7:0]         drop_count;

    phasemean_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .K           (k_in),
        .phase_valid (phase_valid),
        .in_phase_1  (ph[0]),
        .in_phase_2  (ph[1]),
        .in_phase_3  (ph[2]),
        .in_phase_4  (ph[3]),
        .in_phase_5  (ph[4]),
        .in_phase_6  (ph[5]),
        .pm_enable   (pm_enable),
        .pm_sampl_1  (smp[0]),
        .pm_sampl_2  (smp[1]),
        .pm_sampl_3  (smp[2]),
        .pm_sampl_4  (smp[3]),
        .pm_sampl_5  (smp[4]),
        .pm_sampl_6  (smp[5]),
        .pm_K        (pm_K),
        .busy        (busy),
        .mean_valid  (mean_valid),
        .set_count   (set_count),
        .drop_count  (drop_count)
    );

    int                 n_chk;
    int                 n_fail;
    longint             cyc;
    set_t               exp_q [$];
    set_t               pend;
    logic [5:0]         pend_got;
    int                 n_pushed;
    logic signed [15:0] din [6];
    int                 n_pulse;
    int                 run_pulses;
    int                 exp_n;
    longint             last_pulse_cyc;
    longint             sum1;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc++;

    task automatic check_eq(input string tag, input logic signed [63:0] obs,
                            input logic signed [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Every issued set must be the next complete set the model assembled.
    always @(negedge clock) begin
        set_t e;
        if (reset && pm_enable) begin
            n_pulse++;
            run_pulses++;
            last_pulse_cyc = cyc;
            sum1 += longint'(smp[0]);
            check_eq("set_count_at_issue", set_count, run_pulses);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_enable", 1, 0);
            end else begin
                e = exp_q.pop_front();
                for (int i = 0; i < 6; i++)
                    check_eq($sformatf("pm_sampl_%0d", i + 1), smp[i], $signed(e[i]));
            end
        end
        if (reset && mean_valid) begin
            check_eq("mean_valid_latency", cyc - last_pulse_cyc, SETTLE_C + 1);
            check_eq("sets_per_run", run_pulses, exp_n);
        end
    end

    task automatic rand_din();
        for (int i = 0; i < 6; i++) din[i] = 16'($urandom);
    endtask

    task automatic strobe(input logic [5:0] v);
        for (int i = 0; i < 6; i++) ph[i] = v[i] ? din[i] : 16'($urandom);
        phase_valid = v;
        @(posedge clock);
        for (int i = 0; i < 6; i++) if (v[i]) pend[i] = din[i];
        pend_got |= v;
        if (pend_got == 6'h3F) begin
            exp_q.push_back(pend);
            pend_got = '0;
            n_pushed++;
        end
        @(negedge clock);
        phase_valid = '0;
    endtask

    task automatic do_start(input int k, input bit accept);
        k_in  = 10'(k);
        start = 1'b1;
        @(posedge clock);
        if (accept) begin
            run_pulses = 0;
            sum1       = 0;
            exp_n      = 1 << ((k > 10) ? 10 : k);
        end
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic full_sets(input int n);
        for (int s = 0; s < n; s++) begin
            rand_din();
            strobe(6'h3F);
            @(negedge clock);
        end
    endtask

    task automatic wait_mv(input int budget, input string tag);
        int i = 0;
        while (!mean_valid && i < budget) begin
            @(negedge clock);
            i++;
        end
        check_eq(tag, mean_valid, 1);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_pm_enable"}, pm_enable, 0);
        check_eq({tag, "_pm_K"}, pm_K, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_mean_valid"}, mean_valid, 0);
        check_eq({tag, "_set_count"}, set_count, 0);
        check_eq({tag, "_drop_count"}, drop_count, 0);
        for (int i = 0; i < 6; i++) check_eq($sformatf("%s_pm_sampl_%0d", tag, i + 1), smp[i], 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int p0;
        int guard;
        n_chk = 0; n_fail = 0; n_pulse = 0; run_pulses = 0; exp_n = 0;
        n_pushed = 0; pend = '0; pend_got = '0; sum1 = 0; last_pulse_cyc = 0;
        reset = 1'b0; start = 1'b0; k_in = '0; phase_valid = '0;
        for (int i = 0; i < 6; i++) begin
            ph[i]  = '0;
            din[i] = '0;
        end

        repeat (3) @(negedge clock);
        check_zero("reset");
        reset = 1'b1;
        @(negedge clock);

        // Basic run: eight simultaneous sets, ch1 alternating 1000/2000.
        do_start(3, 1'b1);
        check_eq("busy_after_start", busy, 1);
        check_eq("basic_pm_K", pm_K, 3);
        for (int s = 0; s < 8; s++) begin
            rand_din();
            din[0] = (s % 2 == 0) ? 16'sd1000 : 16'sd2000;
            din[2] = -16'sd5985;
            strobe(6'h3F);
            @(negedge clock);
        end
        wait_mv(20, "basic_mean_valid");
        check_eq("basic_set_count", set_count, 8);
        check_eq("basic_ch1_mean", sum1 / 8, 1500);
        check_eq("basic_busy_done", busy, 0);
        @(negedge clock);
        check_eq("mean_valid_one_cycle", mean_valid, 0);

        // Staggered arrival with a duplicate on ch2, then a random-mask set.
        do_start(1, 1'b1);
        rand_din();
        strobe(6'h01);
        din[1] = 16'sd17000;
        strobe(6'h02);
        strobe(6'h04);
        din[1] = 16'sd17500;
        strobe(6'h02);
        strobe(6'h08);
        strobe(6'h10);
        strobe(6'h20);
        check_eq("stagger_enable_early", pm_enable, 0);
        @(negedge clock);
        check_eq("stagger_enable", pm_enable, 1);
        check_eq("dup_latest_wins", smp[1], 17500);
        p0 = n_pushed;
        guard = 0;
        while (n_pushed == p0 && guard < 60) begin
            rand_din();
            strobe(6'($urandom_range(1, 63)));
            guard++;
        end
        wait_mv(20, "stagger_mean_valid");

        // Channel 6 silent after a partial set.
        do_start(1, 1'b1);
        rand_din();
        strobe(6'h1F);
        n0 = n_pulse;
`ifdef PHASEMEAN_CTRL_TIMEOUT_EN
        repeat (63) @(negedge clock);
        check_eq("timeout_not_yet", drop_count, 0);
        @(negedge clock);
        check_eq("timeout_drop", drop_count, 1);
        pend_got = '0;
`else
        repeat (80) @(negedge clock);
        check_eq("no_timeout_drop", drop_count, 0);
`endif
        check_eq("timeout_no_enable", n_pulse - n0, 0);
        check_eq("timeout_set_count", set_count, 0);
        full_sets(2);
        wait_mv(20, "timeout_mean_valid");

        // K above KMAX clamps to 1024 sets.
        do_start(15, 1'b1);
        check_eq("clamp_pm_K", pm_K, 10);
        full_sets(1024);
        wait_mv(20, "clamp_mean_valid");
        check_eq("clamp_set_count", set_count, 1024);

        // Start while busy is ignored; reset mid-set clears everything.
        do_start(4, 1'b1);
        full_sets(5);
        check_eq("mid_set_count", set_count, 5);
        do_start(9, 1'b0);
        check_eq("ignored_start_count", set_count, 5);
        check_eq("ignored_start_pm_K", pm_K, 4);
        rand_din();
        strobe(6'h07);
        #2 reset = 1'b0;
        #1 check_zero("async_reset");
        exp_q.delete();
        pend_got = '0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        do_start(0, 1'b1);
        n0 = n_pulse;
        rand_din();
        strobe(6'h38);
        repeat (3) @(negedge clock);
        check_eq("partial_discarded", n_pulse - n0, 0);
        rand_din();
        strobe(6'h07);
        wait_mv(20, "post_reset_mean_valid");
        check_eq("post_reset_one_set", n_pulse - n0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
